// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending latch.
// The latch feeds the 8-to-3 priority encoder, so the default width
// matches the encoder input and the index width matches its output.
package irq_pkg;

    localparam int IRQ_N           = 8;
    localparam int IRQ_IDX_W       = 3;
    localparam int SYNC_STAGES_DEF = 2;

    typedef logic [IRQ_N-1:0]     irq_vec_t;
    typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

    // Expand an acknowledge index into a one-hot vector; out-of-range
    // indices produce an all-zero vector.
    function automatic irq_vec_t idx_to_onehot(input irq_idx_t idx);
        irq_vec_t v;
        v = {IRQ_N{1'b0}};
        for (int i = 0; i < IRQ_N; i++) begin
            if (idx == IRQ_IDX_W'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// One-bit synchroniser plus rising-edge detector.
// The asynchronous input passes through SYNC_STAGES flops (2..3); a history
// flop holds the previous synchronised value, so a held-high input produces
// exactly one edge. The edge output is combinational from flops only.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Synchroniser chain and edge history; cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign edge_out = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/irq_pending_latch.sv
// Interrupt pending latch ahead of the 8-to-3 priority encoder.
// Each request line is synchronised and edge-detected; a detected edge sets
// a sticky pending bit that stays until acknowledged by index. The masked
// pending vector drives the encoder, whose output returns as ack_idx.
// Optional feature macro: IRQ_OVERFLOW_EN (sticky lost-edge flags).
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int N           = IRQ_N,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int IDX_W       = IRQ_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     pend_out,
    output logic             pend_valid,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [N-1:0]     overflow
);

    logic [N-1:0] w_edge;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pend_nxt;
    logic [N-1:0] r_pend;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_line
            sync_edge_det #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge_det (
                .clk      (clk),
                .rst_n    (rst_n),
                .d_async  (req_in[g]),
                .edge_out (w_edge[g])
            );
        end
    endgenerate

    // Decode the acknowledge: only a visible pending bit in range is cleared;
    // indices at or above N match no line and are ignored.
    always_comb begin
        w_clr = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (ack && (ack_idx == IDX_W'(i))) begin
                w_clr[i] = pend_out[i];
            end else begin
                w_clr[i] = 1'b0;
            end
        end
    end

    // A new edge wins over a same-cycle clear so the fresh request is kept.
    assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;

    // Sticky pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= {N{1'b0}};
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

`ifdef IRQ_OVERFLOW_EN
    logic [N-1:0] r_ovf;

    // An edge landing on an already-pending bit is lost, whether or not the
    // same cycle acknowledges it (a valid clear implies the bit was pending).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= {N{1'b0}};
        end else begin
            r_ovf <= r_ovf | (w_edge & r_pend);
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = {N{1'b0}};
`endif

    assign pend_out   = r_pend & mask;
    assign pend_valid = |pend_out;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed self-checking bench for irq_pending_latch (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_irq_pending_latch;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic [7:0] pend_out;
    logic       pend_valid;
    logic       ack;
    logic [2:0] ack_idx;
    logic [7:0] overflow;

    int checks;
    int failures;

`ifdef IRQ_OVERFLOW_EN
    localparam logic [7:0] OVF_AFTER_COLL = 8'h08;
`else
    localparam logic [7:0] OVF_AFTER_COLL = 8'h00;
`endif

    logic [7:0] drain_seq [4];
    logic [2:0] drain_idx [3];

    irq_pending_latch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .mask       (mask),
        .pend_out   (pend_out),
        .pend_valid (pend_valid),
        .ack        (ack),
        .ack_idx    (ack_idx),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Reference priority encoder: highest set bit wins.
    function automatic logic [2:0] enc8(input logic [7:0] d);
        logic [2:0] y;
        y = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) y = 3'(i);
        end
        return y;
    endfunction

    task automatic test_reset();
        logic [7:0] exp_v;
        rst_n = 1'b0; req_in = 8'hFF; mask = 8'hFF; ack = 1'b0; ack_idx = 3'd0;
        tick(3);
        checks++;
        if (pend_out !== 8'h00 || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold pend_out=%h valid=%b exp=00/0", pend_out, pend_valid);
        end
        checks++;
        if (overflow !== 8'h00) begin
            failures++;
            $display("FAIL reset_ovf got=%h exp=00", overflow);
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (pend_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_fill2 got=%h exp=00", pend_out);
        end
        tick(1);
        checks++;
        if (pend_out !== 8'hFF || pend_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_fill3 pend_out=%h valid=%b exp=ff/1", pend_out, pend_valid);
        end
        // Drain every line while requests stay high: no re-set may occur.
        exp_v = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            ack = 1'b1; ack_idx = 3'(i);
            tick(1);
            ack = 1'b0;
            exp_v[i] = 1'b0;
            checks++;
            if (pend_out !== exp_v) begin
                failures++;
                $display("FAIL reset_drain%0d got=%h exp=%h", i, pend_out, exp_v);
            end
        end
        req_in = 8'h00;
        tick(4);
    endtask

    task automatic test_single();
        req_in = 8'h04;
        tick(2);
        checks++;
        if (pend_out !== 8'h00) begin
            failures++;
            $display("FAIL single_early got=%h exp=00", pend_out);
        end
        tick(1);
        checks++;
        if (pend_out !== 8'h04 || pend_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_set pend_out=%h valid=%b exp=04/1", pend_out, pend_valid);
        end
        // Ack of a non-pending line changes nothing.
        ack = 1'b1; ack_idx = 3'd5;
        tick(1);
        ack = 1'b0;
        checks++;
        if (pend_out !== 8'h04) begin
            failures++;
            $display("FAIL single_badack got=%h exp=04", pend_out);
        end
        ack = 1'b1; ack_idx = 3'd2;
        tick(1);
        ack = 1'b0;
        checks++;
        if (pend_out !== 8'h00 || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_ack pend_out=%h valid=%b exp=00/0", pend_out, pend_valid);
        end
        tick(5);
        checks++;
        if (pend_out !== 8'h00) begin
            failures++;
            $display("FAIL single_held got=%h exp=00", pend_out);
        end
        checks++;
        if (overflow !== 8'h00) begin
            failures++;
            $display("FAIL single_ovf got=%h exp=00", overflow);
        end
        req_in = 8'h00;
        tick(4);
    endtask

    task automatic test_priority_drain();
        logic [2:0] y;
        req_in = 8'hA2;
        tick(2);
        req_in = 8'h00;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pend_out !== drain_seq[k]) begin
                failures++;
                $display("FAIL drain_seq%0d got=%h exp=%h", k, pend_out, drain_seq[k]);
            end
            y = enc8(pend_out);
            checks++;
            if (y !== drain_idx[k]) begin
                failures++;
                $display("FAIL drain_idx%0d got=%0d exp=%0d", k, y, drain_idx[k]);
            end
            ack = 1'b1; ack_idx = y;
            tick(1);
            ack = 1'b0;
        end
        checks++;
        if (pend_out !== drain_seq[3] || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_end pend_out=%h valid=%b exp=00/0", pend_out, pend_valid);
        end
        tick(3);
    endtask

    task automatic test_mask();
        mask = 8'h0F;
        req_in = 8'h40;
        tick(2);
        req_in = 8'h00;
        tick(1);
        checks++;
        if (pend_out !== 8'h00 || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL mask_hidden pend_out=%h valid=%b exp=00/0", pend_out, pend_valid);
        end
        ack = 1'b1; ack_idx = 3'd6;
        tick(1);
        ack = 1'b0;
        mask = 8'hFF;
        #1;
        checks++;
        if (pend_out !== 8'h40 || pend_valid !== 1'b1) begin
            failures++;
            $display("FAIL mask_expose pend_out=%h valid=%b exp=40/1", pend_out, pend_valid);
        end
        @(negedge clk);
        ack = 1'b1; ack_idx = 3'd6;
        tick(1);
        ack = 1'b0;
        checks++;
        if (pend_out !== 8'h00) begin
            failures++;
            $display("FAIL mask_clear got=%h exp=00", pend_out);
        end
        tick(3);
    endtask

    task automatic test_collision();
        req_in = 8'h08;
        tick(2);
        req_in = 8'h00;
        tick(4);
        checks++;
        if (pend_out !== 8'h08) begin
            failures++;
            $display("FAIL coll_setup got=%h exp=08", pend_out);
        end
        // New rising edge on bit 3 reaches the edge detector after two edges;
        // acknowledge bit 3 in exactly that cycle.
        req_in = 8'h08;
        tick(2);
        ack = 1'b1; ack_idx = 3'd3;
        tick(1);
        ack = 1'b0;
        checks++;
        if (pend_out !== 8'h08) begin
            failures++;
            $display("FAIL coll_keep got=%h exp=08", pend_out);
        end
        checks++;
        if (overflow !== OVF_AFTER_COLL) begin
            failures++;
            $display("FAIL coll_ovf got=%h exp=%h", overflow, OVF_AFTER_COLL);
        end
        req_in = 8'h00;
        ack = 1'b1; ack_idx = 3'd3;
        tick(1);
        ack = 1'b0;
        tick(3);
        checks++;
        if (pend_out !== 8'h00) begin
            failures++;
            $display("FAIL coll_clear got=%h exp=00", pend_out);
        end
    endtask

    task automatic test_async_reset();
        req_in = 8'h81;
        tick(2);
        req_in = 8'h00;
        tick(2);
        checks++;
        if (pend_out !== 8'h81) begin
            failures++;
            $display("FAIL arst_setup got=%h exp=81", pend_out);
        end
        checks++;
        if (overflow !== OVF_AFTER_COLL) begin
            failures++;
            $display("FAIL arst_ovf_before got=%h exp=%h", overflow, OVF_AFTER_COLL);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pend_out !== 8'h00 || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_now pend_out=%h valid=%b exp=00/0", pend_out, pend_valid);
        end
        checks++;
        if (overflow !== 8'h00) begin
            failures++;
            $display("FAIL arst_ovf got=%h exp=00", overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        checks++;
        if (pend_out !== 8'h00) begin
            failures++;
            $display("FAIL arst_after got=%h exp=00", pend_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drain_seq[0] = 8'hA2; drain_seq[1] = 8'h22;
        drain_seq[2] = 8'h02; drain_seq[3] = 8'h00;
        drain_idx[0] = 3'd7;  drain_idx[1] = 3'd5; drain_idx[2] = 3'd1;
        test_reset();
        test_single();
        test_priority_drain();
        test_mask();
        test_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
